scan_chain_ctrl: RTL



---
 rtl/scan_chain_ctrl_pkg.sv | 16 +
 rtl/scan_misr.sv | 35 +++
 rtl/scan_chain_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/scan_chain_ctrl_pkg.sv
// Shared types and helpers for the scan-chain controller and its signature register.
package scan_chain_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CAPTURE
  } state_t;

  localparam logic [15:0] DEFAULT_MISR_POLY = 16'h1021;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scan_misr.sv
// Serial-input MISR: one shift per enabled cycle, clr wins over update.
// Latency 1 cycle; no backpressure, it follows en unconditionally.
module scan_misr
  import scan_chain_ctrl_pkg::*;
#(
  parameter int                MISR_W    = 16,
  parameter logic [MISR_W-1:0] MISR_POLY = MISR_W'(DEFAULT_MISR_POLY)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              en,
  input  logic              clr,
  input  logic              din,
  output logic [MISR_W-1:0] sig
);

  logic [MISR_W-1:0] sig_nxt;

  always_comb begin
    sig_nxt = {sig[MISR_W-2:0], 1'b0}
            ^ (sig[MISR_W-1] ? MISR_POLY : '0)
            ^ {{(MISR_W-1){1'b0}}, din};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= sig_nxt;
    end
  end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan shift/capture controller: CHAIN_LEN shift cycles + 1 capture, response after CHAIN_LEN+2 cycles.
// A pending response blocks new patterns (PAT_READY low) until RSP_READY consumes it.
module scan_chain_ctrl
  import scan_chain_ctrl_pkg::*;
#(
  parameter int                CHAIN_LEN = 32,
  parameter int                MISR_W    = 16,
  parameter logic [MISR_W-1:0] MISR_POLY = MISR_W'(DEFAULT_MISR_POLY)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 PAT_VALID,
  output logic                 PAT_READY,
  input  logic [CHAIN_LEN-1:0] PAT_DATA,
  output logic                 SE,
  output logic                 SI,
  output logic                 CKE,
  input  logic                 SO,
  output logic                 RSP_VALID,
  input  logic                 RSP_READY,
  output logic [CHAIN_LEN-1:0] RSP_DATA,
  output logic [MISR_W-1:0]    SIG,
  input  logic                 SIG_CLR,
  output logic                 BUSY
);

  localparam int            CW   = cnt_width(CHAIN_LEN);
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

  state_t               state;
  state_t               state_nxt;
  logic                 accept;
  logic [CW-1:0]        cnt;
  logic [CHAIN_LEN-1:0] pat_sr;

  assign PAT_READY = (state == IDLE) && !RSP_VALID;
  assign BUSY      = (state != IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (PAT_VALID && !RSP_VALID) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == LAST) begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // SE/SI/CKE are registered, so each is loaded one edge ahead of the cycle it applies to.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt       <= '0;
      pat_sr    <= '0;
      SE        <= 1'b0;
      SI        <= 1'b0;
      CKE       <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_DATA  <= '0;
    end else begin
      if (RSP_VALID && RSP_READY) begin
        RSP_VALID <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            cnt    <= '0;
            pat_sr <= PAT_DATA >> 1;
            SI     <= PAT_DATA[0];
            SE     <= 1'b1;
            CKE    <= 1'b1;
          end
        end
        SHIFT: begin
          // Bit sampled on shift cycle k lands in RSP_DATA[k] after the last shift.
          RSP_DATA <= {SO, RSP_DATA[CHAIN_LEN-1:1]};
          if (cnt == LAST) begin
            SE <= 1'b0;
            SI <= 1'b0;
          end else begin
            cnt    <= cnt + 1'b1;
            SI     <= pat_sr[0];
            pat_sr <= pat_sr >> 1;
          end
        end
        CAPTURE: begin
          CKE       <= 1'b0;
          RSP_VALID <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  scan_misr #(
    .MISR_W    (MISR_W),
    .MISR_POLY (MISR_POLY)
  ) u_misr (
    .CLK (CLK),
    .RST (RST),
    .en  (state == SHIFT),
    .clr (SIG_CLR),
    .din (SO),
    .sig (SIG)
  );

endmodule
